dds_sweep_ctrl: RTL and testbench

Frequency-sweep scheduler for the DDS phase-accumulator path. It latches a sweep configuration on a start request, then steps the frequency control word through a programmed list of points, each held for a fixed number of clocks. It drives the FWORD/PWORD inputs of the DDS address generator, and presents a one-cycle update strobe plus busy/done status to the system controller.

---
 rtl/dds_sweep_ctrl_if.sv | 33 +++
 rtl/dds_sweep_ctrl.sv | 113 +++++++++++
 tb/tb_dds_sweep_ctrl.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dds_sweep_ctrl_if.sv
// Sweep controller bus: configuration and handshake from the system controller,
// plus the frequency/phase words and status returned by the sweep scheduler.
interface dds_sweep_ctrl_if #(
  parameter int N  = 32,
  parameter int PW = 8,
  parameter int CW = 16
);
  logic          start;
  logic          abort;
  logic          repeat_en;
  logic [N-1:0]  cfg_fstart;
  logic [N-1:0]  cfg_fstep;
  logic [CW-1:0] cfg_points;
  logic [CW-1:0] cfg_dwell;
  logic [PW-1:0] cfg_pword;

  logic [N-1:0]  fword;
  logic [PW-1:0] pword;
  logic          upd;
  logic          busy;
  logic          done;
  logic [CW-1:0] point_idx;

  modport master (
    output start, abort, repeat_en, cfg_fstart, cfg_fstep, cfg_points, cfg_dwell, cfg_pword,
    input  fword, pword, upd, busy, done, point_idx
  );

  modport slave (
    input  start, abort, repeat_en, cfg_fstart, cfg_fstep, cfg_points, cfg_dwell, cfg_pword,
    output fword, pword, upd, busy, done, point_idx
  );
endinterface

// File: rtl/dds_sweep_ctrl.sv
// Frequency-sweep scheduler: steps the DDS frequency word through a list of
// points, holding each for a fixed dwell, with optional continuous repeat.
module dds_sweep_ctrl #(
  parameter int N  = 32,
  parameter int PW = 8,
  parameter int CW = 16
) (
  input  logic            clk,
  input  logic            rst,
  dds_sweep_ctrl_if.slave bus
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]    state;
  logic [CW-1:0] dwell_cnt;
  logic [CW-1:0] points_q;
  logic [CW-1:0] dwell_q;
  logic [N-1:0]  fstart_q;
  logic [N-1:0]  fstep_q;
  logic          rep_q;

  logic [N-1:0]  fword_q;
  logic [PW-1:0] pword_q;
  logic          upd_q;
  logic          busy_q;
  logic          done_q;
  logic [CW-1:0] idx_q;

  logic [CW-1:0] eff_points;
  logic [CW-1:0] eff_dwell;
  logic          last_point;

  // A zero count from the controller means a single point / single clock.
  assign eff_points = (bus.cfg_points == '0) ? CW'(1) : bus.cfg_points;
  assign eff_dwell  = (bus.cfg_dwell  == '0) ? CW'(1) : bus.cfg_dwell;
  assign last_point = (idx_q == points_q - CW'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      dwell_cnt <= '0;
      points_q  <= '0;
      dwell_q   <= '0;
      fstart_q  <= '0;
      fstep_q   <= '0;
      rep_q     <= 1'b0;
      fword_q   <= '0;
      pword_q   <= '0;
      upd_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      idx_q     <= '0;
    end else begin
      upd_q  <= 1'b0;
      done_q <= 1'b0;
      if (bus.abort) begin
        state  <= IDLE;
        busy_q <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (bus.start) begin
              fstart_q  <= bus.cfg_fstart;
              fstep_q   <= bus.cfg_fstep;
              points_q  <= eff_points;
              dwell_q   <= eff_dwell;
              rep_q     <= bus.repeat_en;
              fword_q   <= bus.cfg_fstart;
              pword_q   <= bus.cfg_pword;
              idx_q     <= '0;
              upd_q     <= 1'b1;
              busy_q    <= 1'b1;
              dwell_cnt <= eff_dwell - CW'(1);
              state     <= RUN;
            end
          end
          RUN: begin
            // The step to the next point happens on the dwell-terminal edge itself,
            // so consecutive points abut with no extra clock.
            if (dwell_cnt != '0) begin
              dwell_cnt <= dwell_cnt - CW'(1);
            end else if (!last_point) begin
              fword_q   <= fword_q + fstep_q;
              idx_q     <= idx_q + CW'(1);
              upd_q     <= 1'b1;
              dwell_cnt <= dwell_q - CW'(1);
            end else if (rep_q) begin
              fword_q   <= fstart_q;
              idx_q     <= '0;
              upd_q     <= 1'b1;
              dwell_cnt <= dwell_q - CW'(1);
            end else begin
              busy_q <= 1'b0;
              done_q <= 1'b1;
              state  <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.fword     = fword_q;
  assign bus.pword     = pword_q;
  assign bus.upd       = upd_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.point_idx = idx_q;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Bench for dds_sweep_ctrl: a closed-form sweep model checked every cycle,
// directed scenarios pinned to hand-computed values, then random traffic.
module tb_dds_sweep_ctrl;
  localparam int N  = 32;
  localparam int PW = 8;
  localparam int CW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dds_sweep_ctrl_if #(.N(N), .PW(PW), .CW(CW)) ifc ();

  dds_sweep_ctrl #(.N(N), .PW(PW), .CW(CW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(ifc)
  );

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  bit            m_active = 0;
  longint        m_t = 0;
  longint        m_P = 1;
  longint        m_D = 1;
  logic [N-1:0]  m_fstart = '0;
  logic [N-1:0]  m_fstep = '0;
  bit            m_rep = 0;
  logic [N-1:0]  m_fword = '0;
  logic [PW-1:0] m_pword = '0;
  bit            m_upd = 0;
  bit            m_busy = 0;
  bit            m_done = 0;
  longint        m_idx = 0;
  bit            cmp_en = 0;

  task automatic checkOutput(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s at t=%0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic pin(string name, logic [63:0] dut_v, logic [63:0] mod_v, logic [63:0] lit);
    checkOutput({name, "_model"}, mod_v, lit);
    checkOutput(name, dut_v, lit);
  endtask

  // Position within the sweep follows directly from the cycles elapsed since start.
  task automatic evalPoint();
    longint j;
    longint i;
    j = m_t % (m_P * m_D);
    i = j / m_D;
    m_fword = m_fstart + N'(i) * m_fstep;
    m_idx   = i;
    m_upd   = ((j % m_D) == 0);
    m_busy  = 1;
    m_done  = 0;
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_active = 0; m_fword = '0; m_pword = '0; m_upd = 0;
      m_busy = 0; m_done = 0; m_idx = 0;
    end else if (ifc.abort) begin
      m_active = 0; m_busy = 0; m_upd = 0; m_done = 0;
    end else if (!m_active) begin
      m_upd  = 0;
      m_done = 0;
      if (ifc.start) begin
        m_fstart = ifc.cfg_fstart;
        m_fstep  = ifc.cfg_fstep;
        m_P      = (ifc.cfg_points == 0) ? 1 : longint'(ifc.cfg_points);
        m_D      = (ifc.cfg_dwell  == 0) ? 1 : longint'(ifc.cfg_dwell);
        m_rep    = ifc.repeat_en;
        m_pword  = ifc.cfg_pword;
        m_t      = 0;
        m_active = 1;
        evalPoint();
      end
    end else begin
      m_t++;
      if (!m_rep && m_t >= m_P * m_D) begin
        m_active = 0; m_busy = 0; m_upd = 0; m_done = 1;
      end else begin
        evalPoint();
      end
    end
    cmp_en = 1;
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      checkOutput("fword",     64'(ifc.fword),     64'(m_fword));
      checkOutput("pword",     64'(ifc.pword),     64'(m_pword));
      checkOutput("upd",       64'(ifc.upd),       64'(m_upd));
      checkOutput("busy",      64'(ifc.busy),      64'(m_busy));
      checkOutput("done",      64'(ifc.done),      64'(m_done));
      checkOutput("point_idx", 64'(ifc.point_idx), 64'(m_idx));
    end
  end

  task automatic nextCycle();
    @(negedge clk);
    cyc++;
  endtask

  task automatic runTo(int n);
    while (cyc < n) nextCycle();
  endtask

  task automatic applyStimulus(logic [N-1:0] fs, logic [N-1:0] st, logic [CW-1:0] pts,
                               logic [CW-1:0] dw, logic rep, logic [PW-1:0] pw);
    ifc.cfg_fstart = fs;
    ifc.cfg_fstep  = st;
    ifc.cfg_points = pts;
    ifc.cfg_dwell  = dw;
    ifc.repeat_en  = rep;
    ifc.cfg_pword  = pw;
    ifc.start      = 1'b1;
    cyc = 0;
  endtask

  task automatic startSweep(logic [N-1:0] fs, logic [N-1:0] st, logic [CW-1:0] pts,
                            logic [CW-1:0] dw, logic rep, logic [PW-1:0] pw);
    applyStimulus(fs, st, pts, dw, rep, pw);
    nextCycle();
    ifc.start = 1'b0;
  endtask

  initial begin
    ifc.start = 0; ifc.abort = 0; ifc.repeat_en = 0;
    ifc.cfg_fstart = '0; ifc.cfg_fstep = '0; ifc.cfg_points = '0;
    ifc.cfg_dwell = '0; ifc.cfg_pword = '0;
    rst = 1;
    repeat (2) @(negedge clk);
    pin("rst_fword", 64'(ifc.fword), 64'(m_fword), 64'd0);
    pin("rst_busy",  64'(ifc.busy),  64'(m_busy),  64'd0);
    pin("rst_idx",   64'(ifc.point_idx), 64'(m_idx), 64'd0);
    rst = 0;
    nextCycle();

    // Basic up-sweep
    startSweep(32'd1000, 32'd500, 16'd3, 16'd4, 1'b0, 8'h5A);
    pin("basic_c1_fword", 64'(ifc.fword), 64'(m_fword), 64'd1000);
    pin("basic_c1_upd",   64'(ifc.upd),   64'(m_upd),   64'd1);
    pin("basic_c1_pword", 64'(ifc.pword), 64'(m_pword), 64'h5A);
    runTo(4);
    pin("basic_c4_fword", 64'(ifc.fword), 64'(m_fword), 64'd1000);
    runTo(5);
    pin("basic_c5_fword", 64'(ifc.fword), 64'(m_fword), 64'd1500);
    pin("basic_c5_upd",   64'(ifc.upd),   64'(m_upd),   64'd1);
    runTo(6);
    pin("basic_c6_upd",   64'(ifc.upd),   64'(m_upd),   64'd0);
    runTo(9);
    pin("basic_c9_fword", 64'(ifc.fword), 64'(m_fword), 64'd2000);
    pin("basic_c9_idx",   64'(ifc.point_idx), 64'(m_idx), 64'd2);
    runTo(12);
    pin("basic_c12_done", 64'(ifc.done),  64'(m_done),  64'd0);
    runTo(13);
    pin("basic_c13_done", 64'(ifc.done),  64'(m_done),  64'd1);
    pin("basic_c13_busy", 64'(ifc.busy),  64'(m_busy),  64'd0);
    pin("basic_c13_fword", 64'(ifc.fword), 64'(m_fword), 64'd2000);
    runTo(14);
    pin("basic_c14_done", 64'(ifc.done),  64'(m_done),  64'd0);

    // Wrap-around modulo 2^N
    startSweep(32'hFFFFFF00, 32'h200, 16'd2, 16'd1, 1'b0, 8'h00);
    pin("wrap_c1", 64'(ifc.fword), 64'(m_fword), 64'hFFFFFF00);
    nextCycle();
    pin("wrap_c2", 64'(ifc.fword), 64'(m_fword), 64'h00000100);
    nextCycle();
    pin("wrap_c3_done", 64'(ifc.done), 64'(m_done), 64'd1);

    // Down-sweep with negative step
    startSweep(32'd100, 32'hFFFFFFCE, 16'd3, 16'd1, 1'b0, 8'h11);
    pin("down_c1", 64'(ifc.fword), 64'(m_fword), 64'd100);
    nextCycle();
    pin("down_c2", 64'(ifc.fword), 64'(m_fword), 64'd50);
    nextCycle();
    pin("down_c3", 64'(ifc.fword), 64'(m_fword), 64'd0);
    nextCycle();
    pin("down_c4_done", 64'(ifc.done), 64'(m_done), 64'd1);

    // Repeat mode A,A,B,B,A,A,B,B then abort
    startSweep(32'd10, 32'd5, 16'd2, 16'd2, 1'b1, 8'h22);
    runTo(3);
    pin("rep_c3", 64'(ifc.fword), 64'(m_fword), 64'd15);
    runTo(5);
    pin("rep_c5", 64'(ifc.fword), 64'(m_fword), 64'd10);
    pin("rep_c5_upd", 64'(ifc.upd), 64'(m_upd), 64'd1);
    runTo(8);
    pin("rep_c8", 64'(ifc.fword), 64'(m_fword), 64'd15);
    pin("rep_c8_busy", 64'(ifc.busy), 64'(m_busy), 64'd1);
    ifc.abort = 1;
    nextCycle();
    ifc.abort = 0;
    pin("rep_abort_busy", 64'(ifc.busy), 64'(m_busy), 64'd0);
    pin("rep_abort_done", 64'(ifc.done), 64'(m_done), 64'd0);
    nextCycle();

    // Abort in the 2nd cycle of point 1, then a normal restart
    startSweep(32'd1000, 32'd500, 16'd3, 16'd4, 1'b0, 8'h33);
    runTo(6);
    ifc.abort = 1;
    nextCycle();
    ifc.abort = 0;
    pin("abort_busy",  64'(ifc.busy),  64'(m_busy),  64'd0);
    pin("abort_done",  64'(ifc.done),  64'(m_done),  64'd0);
    pin("abort_fword", 64'(ifc.fword), 64'(m_fword), 64'd1500);
    nextCycle();
    startSweep(32'd7, 32'd1, 16'd2, 16'd1, 1'b0, 8'h44);
    pin("restart_fword", 64'(ifc.fword), 64'(m_fword), 64'd7);
    pin("restart_busy",  64'(ifc.busy),  64'(m_busy),  64'd1);
    runTo(3);

    // points=0, dwell=0 behave as a single one-cycle point
    startSweep(32'd42, 32'd9, 16'd0, 16'd0, 1'b0, 8'h55);
    pin("degen_c1_fword", 64'(ifc.fword), 64'(m_fword), 64'd42);
    nextCycle();
    pin("degen_c2_done", 64'(ifc.done), 64'(m_done), 64'd1);

    // start and abort together in IDLE
    ifc.abort = 1;
    applyStimulus(32'd77, 32'd1, 16'd2, 16'd2, 1'b0, 8'h66);
    nextCycle();
    ifc.start = 0;
    ifc.abort = 0;
    pin("startabort_busy",  64'(ifc.busy),  64'(m_busy),  64'd0);
    pin("startabort_fword", 64'(ifc.fword), 64'(m_fword), 64'd42);

    // start during a sweep is ignored
    startSweep(32'd1000, 32'd500, 16'd3, 16'd4, 1'b0, 8'h77);
    runTo(3);
    ifc.cfg_fstart = 32'd9999;
    ifc.start = 1;
    nextCycle();
    ifc.start = 0;
    runTo(5);
    pin("busystart_c5", 64'(ifc.fword), 64'(m_fword), 64'd1500);
    runTo(14);

    // Reset in cycle 6 of the basic sweep
    startSweep(32'd1000, 32'd500, 16'd3, 16'd4, 1'b0, 8'h88);
    runTo(6);
    rst = 1;
    nextCycle();
    rst = 0;
    pin("rstmid_fword", 64'(ifc.fword), 64'(m_fword), 64'd0);
    pin("rstmid_pword", 64'(ifc.pword), 64'(m_pword), 64'd0);
    pin("rstmid_busy",  64'(ifc.busy),  64'(m_busy),  64'd0);
    pin("rstmid_upd",   64'(ifc.upd),   64'(m_upd),   64'd0);
    pin("rstmid_idx",   64'(ifc.point_idx), 64'(m_idx), 64'd0);

    // Random traffic against the model
    for (int k = 0; k < 3000; k++) begin
      ifc.cfg_fstart = N'($urandom);
      ifc.cfg_fstep  = N'($urandom);
      ifc.cfg_points = CW'($urandom_range(0, 4));
      ifc.cfg_dwell  = CW'($urandom_range(0, 3));
      ifc.cfg_pword  = PW'($urandom);
      ifc.repeat_en  = ($urandom % 4) == 0;
      ifc.start      = ($urandom % 3) == 0;
      ifc.abort      = ($urandom % 40) == 0;
      rst            = ($urandom % 300) == 0;
      nextCycle();
    end
    ifc.start = 0;
    ifc.abort = 1;
    rst = 0;
    nextCycle();
    ifc.abort = 0;
    repeat (5) nextCycle();

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
